// File: rtl/apb_mig_pkg.sv
// apb_mig_pkg
// Shared types for the APB-to-MIG bridge family.
//   data_t     : MIG user-port data word (32 bits)
//   strb_t     : byte strobes for one data word (4 bits)
//   mig_addr_t : MIG user-port address (28 bits)
package apb_mig_pkg;

    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [27:0] mig_addr_t;

endpackage

// File: rtl/mig_port_arbiter.sv
// mig_port_arbiter
// Shares one MIG user command port between N_REQ requesters using a
// round-robin arbiter with at most one command in flight. Read commands
// record their requester index in an in-order ID FIFO so returned read
// data can be steered back to the requester that issued it.
//
// Ports
//   ui_clk_i, ui_reset_ni         : clock, async active-low reset
//   req_en_i / req_w_en_i         : per-requester command request / write flag
//   req_addr_i/strb_i/data_i      : per-requester command fields
//   req_ready_o                   : one-cycle command-accepted pulse
//   req_valid_o, req_data_o       : one-cycle read-data-valid pulse, shared data
//   mig_en_o, mig_w_en_o          : MIG command valid / write
//   mig_addr_o/strb_o/data_o      : MIG command fields
//   mig_ready_i, mig_w_ready_i    : MIG command ready / write-data ready
//   mig_valid_i, mig_data_i       : MIG read data return
//   err_o                         : sticky, read data seen with no read outstanding
module mig_port_arbiter
    import apb_mig_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int RD_DEPTH = 4
) (
    input  logic                   ui_clk_i,
    input  logic                   ui_reset_ni,
    input  logic [N_REQ-1:0]       req_en_i,
    input  logic [N_REQ-1:0]       req_w_en_i,
    input  mig_addr_t [N_REQ-1:0]  req_addr_i,
    input  strb_t [N_REQ-1:0]      req_strb_i,
    input  data_t [N_REQ-1:0]      req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [N_REQ-1:0]       req_valid_o,
    output data_t                  req_data_o,
    output logic                   mig_en_o,
    output logic                   mig_w_en_o,
    output mig_addr_t              mig_addr_o,
    output strb_t                  mig_strb_o,
    output data_t                  mig_data_o,
    input  logic                   mig_ready_i,
    input  logic                   mig_w_ready_i,
    input  logic                   mig_valid_i,
    input  data_t                  mig_data_i,
    output logic                   err_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = $clog2(RD_DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] elig;

    logic [IDX_W-1:0] id_mem [RD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   rd_count;
    logic             rd_full;
    logic             rd_empty;

    logic accept;
    logic push;
    logic pop;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    assign rd_full  = (rd_count == (PTR_W+1)'(RD_DEPTH));
    assign rd_empty = (rd_count == '0);

    // Writes never consume a FIFO slot, so only reads are gated by fullness.
    assign elig = req_en_i & (req_w_en_i | {N_REQ{~rd_full}});

    // First eligible index at or after rr_ptr; scanning downward lets the
    // smallest offset win.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (elig[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign accept      = mig_en_o & mig_ready_i & (~mig_w_en_o | mig_w_ready_i);
    assign push        = accept & ~mig_w_en_o;
    assign pop         = mig_valid_i & ~rd_empty;
    assign req_ready_o = accept ? idx_onehot(gnt_idx) : '0;

    // Command stage: latch winner in IDLE, hold it on the MIG port until accepted.
    always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
        if (!ui_reset_ni) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            mig_en_o   <= 1'b0;
            mig_w_en_o <= 1'b0;
            mig_addr_o <= '0;
            mig_strb_o <= '0;
            mig_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= ISSUE;
                        gnt_idx    <= pick_idx;
                        mig_en_o   <= 1'b1;
                        mig_w_en_o <= req_w_en_i[pick_idx];
                        mig_addr_o <= req_addr_i[pick_idx];
                        mig_strb_o <= req_strb_i[pick_idx];
                        mig_data_o <= req_data_i[pick_idx];
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        state    <= IDLE;
                        mig_en_o <= 1'b0;
                        rr_ptr   <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ID FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge ui_clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= gnt_idx;
        end
    end

    always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
        if (!ui_reset_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   rd_count <= rd_count + 1'b1;
                2'b01:   rd_count <= rd_count - 1'b1;
                default: rd_count <= rd_count;
            endcase
        end
    end

    // Read-return stage: one cycle from mig_valid_i to the requester pulse.
    always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
        if (!ui_reset_ni) begin
            req_valid_o <= '0;
            req_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            req_valid_o <= pop ? idx_onehot(id_mem[rd_ptr]) : '0;
            if (pop) req_data_o <= mig_data_i;
            if (mig_valid_i && rd_empty) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mig_port_arbiter.sv
module tb_mig_port_arbiter;
    import apb_mig_pkg::*;

    localparam int N_REQ    = 2;
    localparam int RD_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  ui_reset_ni;
    logic [N_REQ-1:0]      req_en;
    logic [N_REQ-1:0]      req_w_en;
    mig_addr_t [N_REQ-1:0] req_addr;
    strb_t [N_REQ-1:0]     req_strb;
    data_t [N_REQ-1:0]     req_data;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      req_valid;
    data_t                 req_rdata;
    logic                  mig_en, mig_w_en;
    mig_addr_t             mig_addr;
    strb_t                 mig_strb;
    data_t                 mig_wdata;
    logic                  mig_ready, mig_w_ready, mig_valid;
    data_t                 mig_rdata;
    logic                  err;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard queues: expected grant order and expected read returns.
    int    exp_gnt_q[$];
    int    exp_rd_idx_q[$];
    data_t exp_rd_data_q[$];

    always #5 clk = ~clk;

    mig_port_arbiter #(.N_REQ(N_REQ), .RD_DEPTH(RD_DEPTH)) dut (
        .ui_clk_i     (clk),
        .ui_reset_ni  (ui_reset_ni),
        .req_en_i     (req_en),
        .req_w_en_i   (req_w_en),
        .req_addr_i   (req_addr),
        .req_strb_i   (req_strb),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .req_valid_o  (req_valid),
        .req_data_o   (req_rdata),
        .mig_en_o     (mig_en),
        .mig_w_en_o   (mig_w_en),
        .mig_addr_o   (mig_addr),
        .mig_strb_o   (mig_strb),
        .mig_data_o   (mig_wdata),
        .mig_ready_i  (mig_ready),
        .mig_w_ready_i(mig_w_ready),
        .mig_valid_i  (mig_valid),
        .mig_data_i   (mig_rdata),
        .err_o        (err)
    );

    // Drive point: just after the rising edge. Sample point: falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_en      = '0;
        req_w_en    = '0;
        req_addr    = '0;
        req_strb    = '0;
        req_data    = '0;
        mig_ready   = 1'b1;
        mig_w_ready = 1'b1;
        mig_valid   = 1'b0;
        mig_rdata   = '0;
    endtask

    task automatic test_reset();
        ui_reset_ni = 1'b0;
        idle_inputs();
        repeat (2) begin cyc(); end
        mid();
        n_cmp++;
        if ({mig_en, mig_w_en, mig_addr, mig_strb, mig_wdata, req_ready, req_valid, req_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got en=%b w=%b addr=%h ready=%b valid=%b rdata=%h, want all zero",
                     mig_en, mig_w_en, mig_addr, req_ready, req_valid, req_rdata);
        end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_alternate_writes();
        int prev;
        int got;
        int e;
        cyc();
        ui_reset_ni = 1'b1;
        req_addr[0] = 28'h100;  req_data[0] = 32'h1111_1111;  req_strb[0] = 4'hF;
        req_addr[1] = 28'h200;  req_data[1] = 32'h2222_2222;  req_strb[1] = 4'h3;
        req_w_en    = 2'b11;
        req_en      = 2'b11;
        for (int i = 0; i < 4; i++) exp_gnt_q.push_back(i % 2);
        prev = -1;
        got  = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            cyc();
            mid();
            if (req_ready !== 2'b00) begin
                e = (exp_gnt_q.size() > 0) ? exp_gnt_q.pop_front() : -1;
                n_cmp++;
                if (e < 0 || req_ready !== (2'b01 << e)) begin
                    n_bad++;
                    $display("FAIL alt_grant_order: got ready=%b want index %0d", req_ready, e);
                end else begin
                    n_cmp++;
                    if ({mig_w_en, mig_addr, mig_strb, mig_wdata} !== {1'b1, req_addr[e], req_strb[e], req_data[e]}) begin
                        n_bad++;
                        $display("FAIL alt_fields: got w=%b addr=%h strb=%h data=%h want requester %0d fields",
                                 mig_w_en, mig_addr, mig_strb, mig_wdata, e);
                    end
                end
                if (prev < 0) begin
                    n_cmp++;
                    if (c != 0) begin n_bad++; $display("FAIL first_grant_latency: got cycle %0d want 0", c); end
                end else begin
                    n_cmp++;
                    if (c - prev != 2) begin n_bad++; $display("FAIL alt_spacing: got %0d cycles want 2", c - prev); end
                end
                prev = c;
                got++;
            end
        end
        req_en = '0;
        n_cmp++;
        if (got != 4) begin n_bad++; $display("FAIL alt_timeout: got %0d grants want 4", got); end
        exp_gnt_q.delete();
        cyc(); cyc(); mid();
        n_cmp++;
        if (mig_en !== 1'b0) begin n_bad++; $display("FAIL alt_idle: mig_en got %b want 0", mig_en); end
    endtask

    task automatic test_read_return();
        int acc;
        int e;
        cyc();
        req_addr[0] = 28'h10;
        req_w_en    = 2'b00;
        req_en      = 2'b01;
        acc = 0;
        for (int c = 0; c < 10 && acc == 0; c++) begin
            cyc();
            mid();
            if (req_ready !== 2'b00) begin
                acc = 1;
                n_cmp++;
                if ({req_ready, mig_w_en, mig_addr} !== {2'b01, 1'b0, 28'h10}) begin
                    n_bad++;
                    $display("FAIL rd_accept: got ready=%b w=%b addr=%h want 01/0/010", req_ready, mig_w_en, mig_addr);
                end
                req_en = '0;
            end
        end
        n_cmp++;
        if (acc == 0) begin n_bad++; $display("FAIL rd_accept_timeout: got no accept want one"); end
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 5) begin
                mig_valid = 1'b1;
                mig_rdata = 32'hA5A5_A5A5;
                exp_rd_idx_q.push_back(0);
                exp_rd_data_q.push_back(32'hA5A5_A5A5);
            end
            mid();
        end
        cyc();
        mig_valid = 1'b0;
        mig_rdata = '0;
        mid();
        e = (exp_rd_idx_q.size() > 0) ? exp_rd_idx_q.pop_front() : 0;
        n_cmp++;
        if (req_valid !== (2'b01 << e)) begin
            n_bad++;
            $display("FAIL rd_valid: got %b want index %0d", req_valid, e);
        end
        if (exp_rd_data_q.size() > 0) begin
            n_cmp++;
            if (req_rdata !== exp_rd_data_q[0]) begin
                n_bad++;
                $display("FAIL rd_data: got %h want %h", req_rdata, exp_rd_data_q[0]);
            end
            void'(exp_rd_data_q.pop_front());
        end
        cyc(); mid();
        n_cmp++;
        if ({req_valid, req_rdata} !== {2'b00, 32'hA5A5_A5A5}) begin
            n_bad++;
            $display("FAIL rd_hold: got valid=%b data=%h want 00/a5a5a5a5", req_valid, req_rdata);
        end
    endtask

    task automatic test_w_ready_stall();
        cyc();
        req_addr[0] = 28'h20;
        req_data[0] = 32'hCAFE_0001;
        req_strb[0] = 4'h5;
        req_w_en    = 2'b01;
        req_en      = 2'b01;
        mig_w_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 2) begin
                req_en      = '0;
                req_addr[0] = 28'h3FF;
                req_data[0] = '0;
            end
            if (k == 4) mig_w_ready = 1'b1;
            mid();
            n_cmp++;
            if ({mig_en, mig_w_en, mig_addr, mig_strb, mig_wdata} !== {2'b11, 28'h20, 4'h5, 32'hCAFE_0001}) begin
                n_bad++;
                $display("FAIL stall_fields c%0d: got en=%b w=%b addr=%h strb=%h data=%h", k,
                         mig_en, mig_w_en, mig_addr, mig_strb, mig_wdata);
            end
            n_cmp++;
            if (req_ready !== ((k == 4) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL stall_ready c%0d: got %b want %b", k, req_ready, (k == 4) ? 2'b01 : 2'b00);
            end
        end
        cyc(); mid();
        n_cmp++;
        if (mig_en !== 1'b0) begin n_bad++; $display("FAIL stall_release: mig_en got %b want 0", mig_en); end
    endtask

    task automatic test_err();
        cyc();
        mig_valid = 1'b1;
        mig_rdata = 32'hDEAD_BEEF;
        mid();
        cyc();
        mig_valid = 1'b0;
        mig_rdata = '0;
        mid();
        n_cmp++;
        if ({err, req_valid, req_rdata} !== {1'b1, 2'b00, 32'hA5A5_A5A5}) begin
            n_bad++;
            $display("FAIL err_set: got err=%b valid=%b data=%h want 1/00/a5a5a5a5", err, req_valid, req_rdata);
        end
        repeat (3) begin cyc(); end
        mid();
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_read_full();
        int got;
        int e;
        cyc();
        req_addr[1] = 28'h80;
        req_w_en    = 2'b00;
        req_en      = 2'b10;
        for (int i = 0; i < RD_DEPTH; i++) exp_gnt_q.push_back(1);
        got = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            mid();
            if (req_ready !== 2'b00) begin
                got++;
                e = (exp_gnt_q.size() > 0) ? exp_gnt_q.pop_front() : -1;
                n_cmp++;
                if (e < 0 || req_ready !== (2'b01 << e)) begin
                    n_bad++;
                    $display("FAIL full_grant: got ready=%b want index %0d", req_ready, e);
                end
                req_addr[1] = req_addr[1] + 28'h4;
            end
        end
        n_cmp++;
        if (got != RD_DEPTH) begin n_bad++; $display("FAIL full_count: got %0d reads accepted want %0d", got, RD_DEPTH); end
        n_cmp++;
        if (mig_en !== 1'b0) begin n_bad++; $display("FAIL full_blocked: mig_en got %b want 0", mig_en); end
        exp_gnt_q.delete();
        cyc();
        req_addr[0] = 28'h30;
        req_data[0] = 32'h0BAD_F00D;
        req_w_en    = 2'b01;
        req_en      = 2'b11;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            cyc();
            mid();
            if (req_ready !== 2'b00) begin
                got = 1;
                n_cmp++;
                if ({req_ready, mig_w_en, mig_addr} !== {2'b01, 1'b1, 28'h30}) begin
                    n_bad++;
                    $display("FAIL full_write: got ready=%b w=%b addr=%h want 01/1/030", req_ready, mig_w_en, mig_addr);
                end
                req_en = '0;
            end
        end
        n_cmp++;
        if (got == 0) begin n_bad++; $display("FAIL full_write_timeout: got no accept want write accepted"); end
    endtask

    task automatic test_reset_mid_issue();
        int got;
        int seen;
        cyc();
        ui_reset_ni = 1'b0;
        idle_inputs();
        mid();
        cyc();
        ui_reset_ni = 1'b1;
        mid();
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err_clear: got %b want 0", err); end
        cyc();
        req_addr[0] = 28'h40;
        req_w_en    = 2'b00;
        req_en      = 2'b01;
        got = 0;
        for (int c = 0; c < 12 && got < 2; c++) begin
            cyc();
            mid();
            if (req_ready === 2'b01) begin
                got++;
                req_addr[0] = req_addr[0] + 28'h4;
                if (got == 2) req_en = '0;
            end
        end
        n_cmp++;
        if (got != 2) begin n_bad++; $display("FAIL rst_setup_reads: got %0d want 2", got); end
        cyc();
        mig_ready   = 1'b0;
        req_addr[1] = 28'h50;
        req_w_en    = 2'b10;
        req_en      = 2'b10;
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            cyc();
            mid();
            if (mig_en === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen == 0 || req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_issue_setup: got mig_en seen=%0d ready=%b want 1/00", seen, req_ready);
        end
        ui_reset_ni = 1'b0;
        #1;
        n_cmp++;
        if ({mig_en, mig_w_en, mig_addr, mig_strb, mig_wdata, req_ready, req_valid, req_rdata, err} !== '0) begin
            n_bad++;
            $display("FAIL rst_async: got en=%b w=%b addr=%h ready=%b valid=%b err=%b want all zero",
                     mig_en, mig_w_en, mig_addr, req_ready, req_valid, err);
        end
        req_en    = '0;
        mig_ready = 1'b1;
        cyc();
        ui_reset_ni = 1'b1;
        mid();
        cyc();
        mig_valid = 1'b1;
        mig_rdata = 32'h7777_7777;
        mid();
        n_cmp++;
        if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_no_ready: got %b want 00", req_ready); end
        cyc();
        mig_valid = 1'b0;
        mid();
        n_cmp++;
        if ({err, req_valid, req_rdata} !== {1'b1, 2'b00, 32'h0}) begin
            n_bad++;
            $display("FAIL rst_discard: got err=%b valid=%b data=%h want 1/00/0", err, req_valid, req_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alternate_writes();
        test_read_return();
        test_w_ready_stall();
        test_err();
        test_read_full();
        test_reset_mid_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mig_port_arbiter.md
MIG_PORT_ARBITER -- requirements
Module: mig_port_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, number of requesters sharing the MIG user port (range 2..4).
REQ-002 The block SHALL have parameter RD_DEPTH, default 4, maximum outstanding reads (power of 2, ≥2).
REQ-003 The block SHALL take data_t, strb_t and mig_addr_t from apb_mig_pkg.
REQ-004 ui_clk_i  input  1  sole clock, rising edge.
REQ-005 ui_reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 req_en_i  input  N_REQ  per-requester command request.
REQ-007 req_w_en_i  input  N_REQ  1=write, 0=read.
REQ-008 req_addr_i  input  N_REQ x mig_addr_t  command address.
REQ-009 req_strb_i  input  N_REQ x strb_t  write byte strobes.
REQ-010 req_data_i  input  N_REQ x data_t  write data.
REQ-011 req_ready_o  output  N_REQ  one-cycle command-accepted pulse.
REQ-012 req_valid_o  output  N_REQ  one-cycle read-data-valid pulse.
REQ-013 req_data_o  output  data_t  read data, shared by all requesters.
REQ-014 mig_en_o, mig_w_en_o  output  1 each  command valid / write.
REQ-015 mig_addr_o, mig_strb_o, mig_data_o  output  mig_addr_t, strb_t, data_t  command fields.
REQ-016 mig_ready_i, mig_w_ready_i, mig_valid_i  input  1 each  MIG command ready / write-data ready / read-data valid.
REQ-017 mig_data_i  input  data_t  MIG read data.
REQ-018 err_o  output  1  sticky: read data returned with no outstanding read.

Function
REQ-019 FSM states SHALL be IDLE and ISSUE.
REQ-020 A requester SHALL be eligible in IDLE when req_en_i[i]=1 and (req_w_en_i[i]=1 or outstanding count < RD_DEPTH).
REQ-021 In IDLE, when ≥1 requester is eligible, the block SHALL pick the first eligible index at or after the round-robin pointer (wrapping), latch the index and all command fields, and go to ISSUE next cycle.
REQ-022 In ISSUE, mig_en_o SHALL be 1 and mig_* command fields SHALL equal the latched values, unchanged until acceptance.
REQ-023 Acceptance SHALL occur in a cycle with mig_en_o=1, mig_ready_i=1 and (mig_w_en_o=0 or mig_w_ready_i=1).
REQ-024 On acceptance, req_ready_o[granted] SHALL be 1 that cycle only, the pointer SHALL become (granted+1) mod N_REQ, and the FSM SHALL return to IDLE.
REQ-025 Minimum command spacing SHALL be 2 cycles (IDLE, ISSUE); the block SHALL have at most one command in flight to the MIG.
REQ-026 A requester SHALL hold req_en_i and fields until its req_ready_o; dropping req_en_i in ISSUE SHALL NOT cancel the latched command.
REQ-027 An accepted read SHALL push the granted index into an in-order ID FIFO of depth RD_DEPTH; outstanding count = FIFO occupancy.
REQ-028 mig_valid_i=1 with FIFO non-empty SHALL pop the head; the next cycle req_valid_o[head]=1 and req_data_o = captured mig_data_i (latency 1).
REQ-029 mig_valid_i=1 with FIFO empty SHALL set err_o=1 (sticky until reset), pulse no req_valid_o, leave FIFO unchanged.
REQ-030 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-031 With count = RD_DEPTH, reads SHALL be skipped by arbitration while writes remain eligible.
REQ-032 Count SHALL never exceed RD_DEPTH nor underflow; FIFO pointers wrap modulo RD_DEPTH.
REQ-033 req_data_o SHALL hold its last value when no req_valid_o is asserted.

Reset
REQ-034 ui_reset_ni=0 SHALL asynchronously force: FSM=IDLE, pointer=0, FIFO empty, err_o=0, mig_en_o=0, mig_w_en_o=0, mig_addr_o/strb_o/data_o=0, req_ready_o=0, req_valid_o=0, req_data_o=0.
REQ-035 Reset during ISSUE SHALL abandon the command with no req_ready_o pulse; outstanding reads SHALL be discarded.
REQ-036 Reset release SHALL be synchronised to ui_clk_i externally; first grant is possible the first edge after release.

Verification
REQ-037 Both requesters write continuously, mig_ready_i=mig_w_ready_i=1 -> grants alternate 0,1,0,1; each req_ready_o every 4 cycles.
REQ-038 Req0 read addr 0x10, mig_valid_i 5 cycles after accept with data 0xA5A5_A5A5 -> req_valid_o[0]=1 one cycle later, req_data_o=0xA5A5_A5A5.
REQ-039 Req1 issues 5 reads, mig_valid_i never asserted -> 4 accepted, 5th never granted; a req0 write is still accepted.
REQ-040 Write granted, mig_ready_i=1 but mig_w_ready_i=0 for 3 cycles -> mig_en_o held with stable fields, req_ready_o only on 4th ISSUE cycle.
REQ-041 mig_valid_i=1 with no outstanding reads -> err_o=1 and stays 1; no req_valid_o.
REQ-042 ui_reset_ni low mid-ISSUE with 2 reads outstanding -> all outputs 0 immediately; later mig_valid_i sets err_o.
